// File: rtl/mult_arbiter_pkg.sv
// rtl/mult_arbiter_pkg.sv - shared width default and FSM encoding for mult_arbiter
package mult_arbiter_pkg;

  localparam int MULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bits needed to count 0..w-1 shift-add iterations (at least one).
  function automatic int cnt_bits(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/mult_arbiter_if.sv
// rtl/mult_arbiter_if.sv - two-requester multiply request/grant/result bundle
interface mult_arbiter_if import mult_arbiter_pkg::*; #(
  parameter int WIDTH = MULT_WIDTH
);

  logic               req0;
  logic [WIDTH-1:0]   a0;
  logic [WIDTH-1:0]   b0;
  logic               gnt0;
  logic               req1;
  logic [WIDTH-1:0]   a1;
  logic [WIDTH-1:0]   b1;
  logic               gnt1;
  logic               busy;
  logic               done;
  logic               owner;
  logic [2*WIDTH-1:0] product;

  modport slave (
    input  req0, a0, b0, req1, a1, b1,
    output gnt0, gnt1, busy, done, owner, product
  );

  modport master (
    output req0, a0, b0, req1, a1, b1,
    input  gnt0, gnt1, busy, done, owner, product
  );

endinterface

// File: rtl/mult_shift_add.sv
// rtl/mult_shift_add.sv - iterative shift-add multiplier datapath
// o_acc_next is the accumulator value after the current step, so the owner can latch it on the last step.
module mult_shift_add import mult_arbiter_pkg::*; #(
  parameter int WIDTH = MULT_WIDTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_load,
  input  logic               i_step,
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  output logic [2*WIDTH-1:0] o_acc_next
);

  logic [2*WIDTH-1:0] r_mcand;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_mplier;
  logic [2*WIDTH-1:0] w_addend;

  assign w_addend   = r_mplier[0] ? r_mcand : '0;
  assign o_acc_next = r_acc + w_addend;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
    end else if (i_load) begin
      r_mcand  <= {{WIDTH{1'b0}}, i_a};
      r_mplier <= i_b;
      r_acc    <= '0;
    end else if (i_step) begin
      r_acc    <= o_acc_next;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
    end
  end

endmodule

// File: rtl/mult_arbiter.sv
// rtl/mult_arbiter.sv - round-robin arbiter sharing one shift-add multiplier between two requesters
module mult_arbiter import mult_arbiter_pkg::*; #(
  parameter int WIDTH = MULT_WIDTH
) (
  input  logic         clk,
  input  logic         reset,
  mult_arbiter_if.slave bus
);

  localparam int CW = cnt_bits(WIDTH);

  state_t             r_state;
  logic [CW-1:0]      r_cnt;
  logic               r_last;
  logic               r_gnt0;
  logic               r_gnt1;
  logic               r_done;
  logic               r_owner;
  logic [2*WIDTH-1:0] r_product;

  logic               w_any;
  logic               w_win;
  logic               w_load;
  logic               w_step;
  logic [WIDTH-1:0]   w_a;
  logic [WIDTH-1:0]   w_b;
  logic [2*WIDTH-1:0] w_acc_next;

  // On a tie the requester not served last wins; r_last also tracks the in-flight owner.
  assign w_any  = bus.req0 | bus.req1;
  assign w_win  = (bus.req0 & bus.req1) ? ~r_last : bus.req1;
  assign w_load = (r_state == IDLE) & w_any;
  assign w_step = (r_state == MUL);
  assign w_a    = w_win ? bus.a1 : bus.a0;
  assign w_b    = w_win ? bus.b1 : bus.b0;

  mult_shift_add #(.WIDTH(WIDTH)) u_datapath (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_load),
    .i_step     (w_step),
    .i_a        (w_a),
    .i_b        (w_b),
    .o_acc_next (w_acc_next)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_last    <= 1'b1;
      r_gnt0    <= 1'b0;
      r_gnt1    <= 1'b0;
      r_done    <= 1'b0;
      r_owner   <= 1'b0;
      r_product <= '0;
    end else begin
      r_gnt0 <= 1'b0;
      r_gnt1 <= 1'b0;
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_state <= MUL;
            r_cnt   <= '0;
            r_last  <= w_win;
            r_gnt0  <= ~w_win;
            r_gnt1  <= w_win;
          end
        end
        MUL: begin
          if (r_cnt == CW'(WIDTH - 1)) begin
            r_state   <= DONE;
            r_done    <= 1'b1;
            r_product <= w_acc_next;
            r_owner   <= r_last;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.gnt0    = r_gnt0;
  assign bus.gnt1    = r_gnt1;
  assign bus.done    = r_done;
  assign bus.owner   = r_owner;
  assign bus.product = r_product;
  assign bus.busy    = (r_state != IDLE);

endmodule

// File: tb/tb_mult_arbiter.sv
// tb/tb_mult_arbiter.sv - self-checking bench for mult_arbiter against a round-robin product model
module tb_mult_arbiter;
  import mult_arbiter_pkg::*;

  localparam int W = MULT_WIDTH;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mult_arbiter_if #(.WIDTH(W)) bus ();

  mult_arbiter #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  bit m_last;
  int m_product;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    m_last    = 1'b1;
    m_product = 0;
  endtask

  // Waits for a grant, predicts winner and product, then follows the operation to done.
  task automatic serve_one(input string tag, input bit drop, input bit poke1, output int gnt_wait);
    bit got, win, bad_gnt, bad_busy, bad_prod;
    int expp, lat;
    got = 0; bad_gnt = 0; bad_busy = 0; bad_prod = 0; lat = 0; gnt_wait = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (bus.gnt0 || bus.gnt1) begin
        got = 1; gnt_wait = k;
        break;
      end
    end
    if (!got) begin
      check({tag, "_gnt_timeout"}, 0, 1);
      return;
    end
    if (bus.req0 && bus.req1) win = !m_last;
    else win = bus.req1;
    m_last = win;
    expp = win ? int'(bus.a1) * int'(bus.b1) : int'(bus.a0) * int'(bus.b0);
    check({tag, "_gnt_who"}, {bus.gnt1, bus.gnt0}, win ? 2 : 1);
    check({tag, "_gnt_busy"}, bus.busy, 1);
    if (drop) begin
      if (win) bus.req1 = 1'b0;
      else bus.req0 = 1'b0;
    end
    if (poke1 && !win) begin
      bus.a1 = 4'd9; bus.b1 = 4'd9; bus.req1 = 1'b1;
    end
    for (int k = 1; k <= W + 4; k++) begin
      @(negedge clk);
      if (bus.done) begin
        lat = k;
        break;
      end
      if (bus.gnt0 || bus.gnt1) bad_gnt = 1;
      if (!bus.busy) bad_busy = 1;
      if (int'(bus.product) != m_product) bad_prod = 1;
    end
    check({tag, "_latency"}, lat, W);
    check({tag, "_no_gnt_while_busy"}, bad_gnt, 0);
    check({tag, "_busy_held"}, bad_busy, 0);
    check({tag, "_prod_held"}, bad_prod, 0);
    if (lat == 0) return;
    check({tag, "_product"}, bus.product, expp);
    check({tag, "_owner"}, bus.owner, win);
    check({tag, "_done_excl"}, bus.gnt0 | bus.gnt1, 0);
    check({tag, "_done_busy"}, bus.busy, 1);
    m_product = expp;
    if (poke1) bus.req1 = 1'b0;
    @(negedge clk);
    check({tag, "_done_pulse"}, bus.done, 0);
    check({tag, "_idle"}, bus.busy, 0);
    check({tag, "_prod_after"}, bus.product, expp);
  endtask

  initial begin
    int  w;
    bit  flag;
    int  sel;
    reset = 1'b1;
    bus.req0 = 1'b1; bus.a0 = 4'd3; bus.b0 = 4'd5;
    bus.req1 = 1'b0; bus.a1 = 4'd0; bus.b1 = 4'd0;
    repeat (3) @(negedge clk);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_gnt0", bus.gnt0, 0);
    check("rst_gnt1", bus.gnt1, 0);
    check("rst_owner", bus.owner, 0);
    check("rst_product", bus.product, 0);
    reset = 1'b0;
    m_last = 1'b1; m_product = 0;

    serve_one("single", 1, 0, w);
    check("single_gnt_wait", w, 1);

    do_reset();
    bus.req0 = 1'b1; bus.a0 = 4'd2; bus.b0 = 4'd7;
    bus.req1 = 1'b1; bus.a1 = 4'd4; bus.b1 = 4'd4;
    serve_one("tie_first", 1, 0, w);
    serve_one("tie_second", 1, 0, w);

    bus.req0 = 1'b1; bus.req1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.a0 = 4'($urandom); bus.b0 = 4'($urandom);
      bus.a1 = 4'($urandom); bus.b1 = 4'($urandom);
      serve_one("fair", 0, 0, w);
    end
    bus.req0 = 1'b0; bus.req1 = 1'b0;

    bus.req0 = 1'b1; bus.a0 = 4'd15; bus.b0 = 4'd15;
    serve_one("max", 1, 0, w);
    bus.req0 = 1'b1; bus.a0 = 4'd0; bus.b0 = 4'd9;
    serve_one("zero", 1, 0, w);
    bus.req0 = 1'b1; bus.a0 = 4'd1; bus.b0 = 4'd15;
    serve_one("one", 1, 0, w);
    flag = 0;
    repeat (5) begin
      @(negedge clk);
      if (int'(bus.product) != 15 || bus.done) flag = 1;
    end
    check("stable_between_done", flag, 0);

    bus.req0 = 1'b1; bus.a0 = 4'd5; bus.b0 = 4'd6;
    serve_one("ignored", 1, 1, w);
    flag = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.gnt0 || bus.gnt1 || bus.done || bus.busy) flag = 1;
    end
    check("ignored_quiet", flag, 0);

    bus.req0 = 1'b1; bus.a0 = 4'd12; bus.b0 = 4'd11;
    flag = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.gnt0) begin
        flag = 1;
        break;
      end
    end
    check("abort_gnt", flag, 1);
    bus.req0 = 1'b0;
    flag = 0;
    repeat (2) begin
      @(negedge clk);
      if (bus.done) flag = 1;
    end
    reset = 1'b1;
    @(negedge clk);
    if (bus.done) flag = 1;
    reset = 1'b0;
    m_last = 1'b1; m_product = 0;
    check("abort_no_done", flag, 0);
    check("abort_product", bus.product, 0);
    check("abort_busy", bus.busy, 0);
    bus.req0 = 1'b1;
    serve_one("abort_fresh", 1, 0, w);

    for (int i = 0; i < 30; i++) begin
      sel = $urandom_range(1, 3);
      bus.req0 = sel[0]; bus.req1 = sel[1];
      bus.a0 = 4'($urandom); bus.b0 = 4'($urandom);
      bus.a1 = 4'($urandom); bus.b1 = 4'($urandom);
      serve_one("rand", 1'($urandom_range(0, 1)), 0, w);
    end
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
